led_serial_tx: RTL and testbench
================================

LED_SERIAL_TX -- requirements
Module: led_serial_tx

Interface
REQ-001 Parameter LEDS, default 50, number of LEDs on the strip (>=1).
REQ-002 Parameter DIV, default 2, clk cycles per clkOut half-period (>=1).
REQ-003 Parameter END_BITS, default max(32, 8*ceil(LEDS/16)), length of the end frame in bits.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  level request to transmit a frame, sampled in IDLE.
REQ-007 done  output  1  high when idle; low while a frame is in progress.
REQ-008 global_bright  input  5  per-frame global brightness, latched at launch.
REQ-009 wr_en  input  1  shadow pixel write strobe.
REQ-010 wr_addr  input  $clog2(LEDS)  LED index of the write.
REQ-011 wr_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-012 dOut  output  1  serial data to strip.
REQ-013 clkOut  output  1  serial clock to strip.

Function
REQ-014 Two pixel stores SHALL exist: a shadow store (written by the host) and an active store (read by the transmitter), each LEDS x 24 bits.
- wr_en writes wr_data into shadow[wr_addr] on the same edge.
- Writes are accepted in any state.
- Writes with wr_addr >= LEDS are ignored.
REQ-015 FSM states SHALL be IDLE, SOF, PIXEL, EOF.
REQ-016 Launch: in IDLE with start=1, the block SHALL do all of the following on one edge, and done SHALL be low from the next cycle.
- Copy the entire shadow store to the active store.
- Latch global_bright.
- Enter SOF.
REQ-017 A write in the launch cycle SHALL land in the shadow store only and SHALL NOT appear in the frame being launched.
REQ-018 SOF SHALL send 32 zero bits.
REQ-019 PIXEL SHALL send, for LED 0..LEDS-1 in order, 32 bits MSB first: 3'b111, latched brightness[4:0], B[7:0], G[7:0], R[7:0].
REQ-020 EOF SHALL send END_BITS one bits, then return to IDLE and raise done.
REQ-021 Bit timing SHALL be as follows.
- Each bit occupies 2*DIV clk cycles: clkOut low for the first DIV cycles, high for the last DIV cycles.
- dOut changes only at the start of a bit, while clkOut is low.
REQ-022 Frame length SHALL be exactly (32 + 32*LEDS + END_BITS)*2*DIV clk cycles, from the first cycle after launch to the cycle done rises.
REQ-023 If start is still high in the cycle done rises, the next launch SHALL occur on the following edge, giving back-to-back frames with one idle cycle.
REQ-024 In IDLE, clkOut and dOut SHALL be 0.
REQ-025 Deasserting start mid-frame SHALL NOT abort the frame.
REQ-026 Bit and LED counters SHALL wrap only at their terminal counts; no partial LED word is ever sent.
REQ-027 Changes to global_bright mid-frame SHALL have no effect until the next launch.

Reset
REQ-028 With rst=0, asynchronously and independently of clk:
- state = IDLE, done = 1, dOut = 0, clkOut = 0;
- shadow store, active store, latched brightness and all counters = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; after release the block sits in IDLE with done = 1.
REQ-030 The first edge after rst rises SHALL be able to accept a launch.

Verification (LEDS=2, DIV=1, END_BITS=32 unless stated)
REQ-031 Write shadow[0]=0xFF0000 and shadow[1]=0x0000FF, global_bright=31, pulse start for 1 cycle, then check:
- done low for 256 cycles;
- on clkOut rising edges, dOut carries 32x0, 0xFF0000FF, 0xFFFF0000, 32x1.
REQ-032 Write shadow[0]=0x123456 in the launch cycle (shadow[0] previously 0): the frame sends LED0 = 0xE0000000; a second frame sends 0xE0563412 (global_bright=0).
REQ-033 Hold start high for two frames: done rises for exactly 1 cycle between frames, and each frame is 256 cycles.
REQ-034 Assert rst mid-PIXEL:
- dOut and clkOut are 0 and done is 1 before the next clk edge;
- after release, a frame with no writes sends all-zero pixels 0xE0000000 (global_bright=0).
REQ-035 Write with wr_addr=3 (LEDS=2): no store changes; a subsequent frame sends the previous pixel values.
REQ-036 LEDS=50, DIV=2: END_BITS=32, and the frame length is (32+1600+32)*4 = 6656 cycles.

Source files
------------

// File: rtl/led_serial_tx.sv
// Serial LED strip transmitter: double-buffered pixel store feeding a start frame,
// one 32-bit word per LED (brightness + BGR), and an end frame of one bits.
module led_serial_tx #(
    parameter int LEDS     = 50,
    parameter int DIV      = 2,
    parameter int END_BITS = (8 * ((LEDS + 15) / 16) > 32) ? 8 * ((LEDS + 15) / 16) : 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         done,
    input  logic [4:0]                   global_bright,
    input  logic                         wr_en,
    // One spare code point so out-of-range addresses are representable and can be rejected
    input  logic [$clog2(LEDS+1)-1:0]    wr_addr,
    input  logic [23:0]                  wr_data,
    output logic                         dOut,
    output logic                         clkOut
);

    localparam int AW = $clog2(LEDS + 1);
    localparam int LW = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int BW = $clog2((END_BITS > 32) ? END_BITS : 32);
    localparam int PW = $clog2(2 * DIV);

    typedef enum logic [1:0] {
        IDLE,
        SOF,
        PIXEL,
        EOF
    } state_t;

    state_t         state, state_nxt;
    logic [23:0]    shadow [LEDS];
    logic [23:0]    active [LEDS];
    logic [4:0]     bright;
    logic [PW-1:0]  ph;
    logic [BW-1:0]  bitcnt;
    logic [LW-1:0]  led;
    logic [31:0]    word;
    logic           launch, bit_end, word_end, eof_end, last_led;

    function automatic logic [31:0] pix_word(input logic [4:0] b, input logic [23:0] p);
        return {3'b111, b, p[7:0], p[15:8], p[23:16]};
    endfunction

    assign launch   = (state == IDLE) && start;
    assign bit_end  = (ph == PW'(2 * DIV - 1));
    assign word_end = bit_end && (bitcnt == BW'(31));
    assign eof_end  = bit_end && (bitcnt == BW'(END_BITS - 1));
    assign last_led = (led == LW'(LEDS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        dOut      = 1'b0;
        clkOut    = 1'b0;
        case (state)
            IDLE: begin
                done = 1'b1;
                if (start) state_nxt = SOF;
            end
            SOF: begin
                clkOut = (ph >= PW'(DIV));
                if (word_end) state_nxt = PIXEL;
            end
            PIXEL: begin
                clkOut = (ph >= PW'(DIV));
                dOut   = word[31];
                if (word_end && last_led) state_nxt = EOF;
            end
            EOF: begin
                clkOut = (ph >= PW'(DIV));
                dOut   = 1'b1;
                if (eof_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Host side: accepted in every state, so a launch-cycle write only reaches the next frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LEDS; i++) shadow[i] <= '0;
        end else if (wr_en && (wr_addr < AW'(LEDS))) begin
            shadow[wr_addr[LW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LEDS; i++) active[i] <= '0;
            bright <= '0;
            ph     <= '0;
            bitcnt <= '0;
            led    <= '0;
            word   <= '0;
        end else if (launch) begin
            active <= shadow;
            bright <= global_bright;
            ph     <= '0;
            bitcnt <= '0;
            led    <= '0;
        end else if (state != IDLE) begin
            ph <= bit_end ? '0 : ph + PW'(1);
            if (bit_end) begin
                bitcnt <= bitcnt + BW'(1);
                word   <= word << 1;
                case (state)
                    SOF: if (word_end) begin
                        bitcnt <= '0;
                        led    <= '0;
                        word   <= pix_word(bright, active[0]);
                    end
                    PIXEL: if (word_end) begin
                        bitcnt <= '0;
                        if (!last_led) begin
                            led  <= led + LW'(1);
                            word <= pix_word(bright, active[led + LW'(1)]);
                        end
                    end
                    EOF: if (eof_end) bitcnt <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_serial_tx.sv
// Directed bench for led_serial_tx (LEDS=2, DIV=1): expected words are queued at launch
// and compared as the serial monitor reassembles them from dOut on clkOut rising edges.
module tb_led_serial_tx;

    localparam int LEDS  = 2;
    localparam int DIV   = 1;
    localparam int FRAME = (32 + 32 * LEDS + 32) * 2 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic [4:0]  global_bright;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic        dOut;
    logic        clkOut;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];

    led_serial_tx #(.LEDS(LEDS), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .global_bright(global_bright), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .dOut(dOut), .clkOut(clkOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial monitor: one bit per clkOut rising edge, MSB first
    logic        prev_ck = 1'b0;
    logic [31:0] sh      = '0;
    int          nb      = 0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_ck = 1'b0;
            nb      = 0;
        end else begin
            if (clkOut && !prev_ck) begin
                sh = {sh[30:0], dOut};
                nb++;
                if (nb == 32) begin
                    nb = 0;
                    check("word_expected", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) check("word", sh, q.pop_front());
                end
            end
            prev_ck = clkOut;
        end
    end

    task automatic expect_frame(input logic [31:0] w0, input logic [31:0] w1);
        q.push_back(32'h0000_0000);
        q.push_back(w0);
        q.push_back(w1);
        q.push_back(32'hFFFF_FFFF);
    endtask

    task automatic write(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at the negedge right after a launch edge; counts cycles with done low
    task automatic frame_len(input string tag);
        int n = 0;
        while (done === 1'b0 && n < 4 * FRAME) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, FRAME);
    endtask

    task automatic launch(input logic [4:0] b);
        global_bright = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int h;
        rst = 1'b0; start = 1'b0; global_bright = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        #3;
        check("rst_done", 32'(done), 32'd1);
        check("rst_dout", 32'(dOut), 32'd0);
        check("rst_clkout", 32'(clkOut), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd1);

        // Write in the launch cycle lands only in the next frame
        expect_frame(32'hE000_0000, 32'hE000_0000);
        global_bright = 5'd0; start = 1'b1;
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'h123456;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        frame_len("len_launch_write");
        expect_frame(32'hE056_3412, 32'hE000_0000);
        launch(5'd0);
        frame_len("len_second");

        // Basic frame; brightness change mid-frame must be ignored
        write(2'd0, 24'hFF0000);
        write(2'd1, 24'h0000FF);
        expect_frame(32'hFF00_00FF, 32'hFFFF_0000);
        launch(5'd31);
        global_bright = 5'd0;
        frame_len("len_basic");
        check("idle_dout", 32'(dOut), 32'd0);
        check("idle_clkout", 32'(clkOut), 32'd0);

        // Out-of-range writes are dropped
        write(2'd3, 24'hABCDEF);
        write(2'd2, 24'h777777);
        expect_frame(32'hFF00_00FF, 32'hFFFF_0000);
        launch(5'd31);
        frame_len("len_oob");

        // Back-to-back frames with start held high
        expect_frame(32'hE100_00FF, 32'hE1FF_0000);
        expect_frame(32'hE100_00FF, 32'hE1FF_0000);
        global_bright = 5'd1; start = 1'b1;
        @(negedge clk);
        frame_len("len_b2b_1");
        h = 0;
        while (done === 1'b1 && h < 10) begin
            h++;
            @(negedge clk);
        end
        check("b2b_idle_cycles", h, 1);
        start = 1'b0;
        frame_len("len_b2b_2");

        // Reset in the middle of the pixel section
        expect_frame(32'hE100_00FF, 32'hE1FF_0000);
        launch(5'd1);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd1);
        check("abort_dout", 32'(dOut), 32'd0);
        check("abort_clkout", 32'(clkOut), 32'd0);
        repeat (2) @(negedge clk);
        q.delete();
        expect_frame(32'hE000_0000, 32'hE000_0000);
        rst = 1'b1;
        launch(5'd0);
        frame_len("len_after_reset");

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
